// File: rtl/reg_file.sv
// Multi-read-port register file with byte-masked writes, write-to-read forwarding,
// an optional hardwired zero entry and a one-entry-per-cycle clear sweep.
module reg_file #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 32,
  parameter int unsigned      NR_RD     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ZERO_REG  = 1'b1,
  parameter bit               BYPASS    = 1'b1,
  localparam int unsigned     AW        = $clog2(DEPTH),
  localparam int unsigned     NB        = WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NB-1:0]          wmask,
  input  logic [NR_RD-1:0]       ren,
  input  logic [NR_RD*AW-1:0]    raddr,
  output logic [NR_RD*WIDTH-1:0] rdata,
  output logic [NR_RD-1:0]       rvalid,
  input  logic                   clr,
  output logic                   busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_acc;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] sweep_val;
  logic [AW-1:0]    ra      [NR_RD];
  logic [WIDTH-1:0] rd_next [NR_RD];

  // Accepted user write and its byte-merged value
  always_comb begin
    wr_acc    = wen && (state == IDLE) && !(ZERO_REG && (waddr == '0));
    wr_merged = mem[waddr];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wmask[b]) wr_merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
    sweep_val = (ZERO_REG && (cnt == '0)) ? '0 : RESET_VAL;
  end

  // Per-port read data, including forwarding of the write landing on this edge
  always_comb begin
    for (int unsigned k = 0; k < NR_RD; k++) begin
      ra[k]      = raddr[k*AW +: AW];
      rd_next[k] = mem[ra[k]];
      if (BYPASS && wr_acc && (waddr == ra[k])) rd_next[k] = wr_merged;
      if (BYPASS && (state == CLEAR) && (cnt == ra[k])) rd_next[k] = RESET_VAL;
      if (ZERO_REG && (ra[k] == '0)) rd_next[k] = '0;
    end
  end

  // Storage, clear-sweep FSM and registered read outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      rdata  <= '0;
      rvalid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
      end
    end else begin
      rvalid <= ren;
      for (int unsigned k = 0; k < NR_RD; k++) begin
        if (ren[k]) rdata[k*WIDTH +: WIDTH] <= rd_next[k];
      end

      case (state)
        IDLE: begin
          if (wr_acc) mem[waddr] <= wr_merged;
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= sweep_val;
          cnt      <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning data width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of entries; legal values are powers of 2, at least 2.
REQ-003 SHALL have parameter NR_RD, default 2, meaning number of read ports, at least 1.
REQ-004 SHALL have parameter RESET_VAL, default 0, meaning the value every entry takes on reset and on clear.
REQ-005 SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to 0 when set to 1.
REQ-006 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when set to 1.
REQ-007 SHALL define AW = log2(DEPTH).
REQ-008 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- wen  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wmask  in  WIDTH/8  byte write mask; bit i enables wdata byte i.
- ren  in  NR_RD  per-port read request.
- raddr  in  NR_RD*AW  packed read addresses; port k uses slice k.
- rdata  out  NR_RD*WIDTH  packed registered read data; port k uses slice k.
- rvalid  out  NR_RD  per-port read-data valid.
- clr  in  1  single-cycle request to clear the whole file.
- busy  out  1  high while a clear sweep is in progress.

Function
REQ-009 Writes SHALL happen on the rising clk edge when wen=1 and busy=0: each byte i of entry waddr with wmask[i]=1 takes wdata byte i; bytes with wmask[i]=0 keep their value.
REQ-010 A write SHALL have no effect when waddr=0 and ZERO_REG=1.
REQ-011 Reads SHALL have a latency of 1 cycle: when ren[k]=1 at edge N, rdata[k] and rvalid[k]=1 SHALL be valid after edge N.
REQ-012 When ren[k]=0 at an edge, rvalid[k] SHALL go to 0 and rdata[k] SHALL hold its previous value.
REQ-013 When ZERO_REG=1, a read of address 0 SHALL return 0 regardless of RESET_VAL or bypass.
REQ-014 For a read and an accepted write to the same address at the same edge:
- BYPASS=1: rdata SHALL return the merged value, meaning new bytes where the mask is set and old bytes elsewhere.
- BYPASS=0: rdata SHALL return the old value.
REQ-015 Any number of read ports SHALL be allowed to read the same address at the same edge, each returning the same data.
REQ-016 The state machine SHALL have two states, IDLE and CLEAR.
- IDLE to CLEAR on clr=1.
- In CLEAR, a sweep counter writes RESET_VAL to entry cnt at each edge, counting from 0 to DEPTH-1.
- CLEAR to IDLE after entry DEPTH-1 is written.
- busy=1 exactly in CLEAR, for DEPTH cycles.
REQ-017 In CLEAR, wen SHALL be ignored and the write dropped; no write is accepted.
REQ-018 In CLEAR, reads SHALL be served and return the entry contents at the sampling edge, so entries with index below cnt read RESET_VAL.
REQ-019 In CLEAR, forwarding SHALL apply to the sweep write: a read of entry cnt returns RESET_VAL when BYPASS=1.
REQ-020 clr=1 while busy=1 SHALL be ignored; the sweep neither restarts nor extends.
REQ-021 clr=1 and wen=1 at the same edge in IDLE: the write SHALL be performed first and the sweep SHALL then overwrite that entry.
REQ-022 Out-of-range conditions SHALL not exist, since DEPTH is a power of 2 and every address is in range.

Reset
REQ-023 When rst=0, asynchronously and without waiting for clk:
- every entry SHALL become RESET_VAL, with entry 0 at 0 when ZERO_REG=1;
- rdata SHALL become 0, rvalid 0 and busy 0;
- the state SHALL become IDLE and the sweep counter 0.
REQ-024 Reset asserted mid-sweep SHALL abort the sweep; after release the block is in IDLE with all entries at RESET_VAL.
REQ-025 The first edge after rst returns to 1 SHALL be a normal operating edge.

Verification
REQ-026 Defaults: write 0x1122334455667788 to entry 5 with wmask=0xFF, then ren[0]=1 with raddr=5 on the next cycle -> rdata[0]=0x1122334455667788 and rvalid[0]=1 one cycle later.
REQ-027 Byte mask: entry 5 holds 0x1122334455667788; write 0xFFFFFFFFFFFFFFFF with wmask=0x0F -> a read returns 0x11223344FFFFFFFF.
REQ-028 Bypass: at the same edge write 0xAB to entry 3 with wmask=0x01 and read entry 3 on both ports.
- BYPASS=1: both ports return the old upper bytes with low byte 0xAB.
- BYPASS=0: both ports return the old value.
REQ-029 Zero register: write 0xDEAD to entry 0, then read it -> rdata=0; repeat with ZERO_REG=0 -> rdata=0xDEAD.
REQ-030 Clear: fill all entries with nonzero data, pulse clr.
- busy SHALL be high for exactly 32 cycles.
- A wen to entry 7 during the sweep SHALL be dropped.
- A second clr pulse during the sweep SHALL be ignored.
- After busy falls, every entry SHALL read RESET_VAL.
REQ-031 Async reset: drive rst=0 between clk edges at sweep count 10 -> busy=0 and rvalid=0 immediately; after release, a read of any entry returns RESET_VAL.
